uart_event_rx: RTL and testbench



---
 rtl/uart_event_pkg.sv | 23 ++
 rtl/uart_rx_core.sv | 143 ++++++++++++++
 rtl/uart_event_rx.sv | 76 +++++++
 tb/tb_uart_event_rx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_event_pkg.sv
// Shared definitions for the collision-event UART link: receiver FSM
// states and the event byte codes used by both the transmit mux and
// the receive decoder.
package uart_event_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam logic [7:0] EVT_BASE     = 8'h40;
  localparam int         EVT_NUM      = 6;

  localparam logic [7:0] EVT_START    = 8'h40;
  localparam logic [7:0] EVT_C1       = 8'h41;
  localparam logic [7:0] EVT_C2       = 8'h42;
  localparam logic [7:0] EVT_C3       = 8'h43;
  localparam logic [7:0] EVT_ENDING   = 8'h44;
  localparam logic [7:0] EVT_POKE_RST = 8'h45;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: input synchronizer, oversampling tick generator,
// receive FSM and byte shifter. Emits a registered done pulse with the
// new byte, or a frame-error pulse when the stop bit samples low.
module uart_rx_core
  import uart_event_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int OVS      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV = CLK_FREQ / (BAUD * OVS);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVS);

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] FULL_LAST = SW'(OVS - 1);

  logic            rx_m;
  logic            rx_s;
  logic [CW-1:0]   tick_cnt;
  logic            tick;
  rx_state_t       state;
  logic [SW-1:0]   scnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            armed;
  logic            start_det;
  logic            full_pt;

  // After a frame error the line may still be low; a new start edge is
  // only accepted once the line has been seen high again (armed).
  assign start_det = (state == IDLE) && armed && !rx_s;
  assign tick      = (tick_cnt == DIV_LAST);
  assign full_pt   = tick && (scnt == FULL_LAST);
  assign busy      = (state != IDLE);

  // Stage: two-flop synchronizer, idle-high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Stage: oversampling tick generator, realigned to every start edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (start_det || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  // Stage: receive FSM with registered done / frame-error outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      scnt      <= '0;
      bit_idx   <= '0;
      armed     <= 1'b1;
      rx_data   <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_s) armed <= 1'b1;
          if (start_det) begin
            state <= START;
            scnt  <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (scnt == HALF_LAST) begin
              if (rx_s) begin
                state <= IDLE;
              end else begin
                state   <= DATA;
                scnt    <= '0;
                bit_idx <= '0;
              end
            end else begin
              scnt <= scnt + SW'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (scnt == FULL_LAST) begin
              scnt <= '0;
              if (bit_idx == 3'd7) state <= STOP;
              else bit_idx <= bit_idx + 3'd1;
            end else begin
              scnt <= scnt + SW'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (scnt == FULL_LAST) begin
              state <= IDLE;
              scnt  <= '0;
              if (rx_s) begin
                rx_data <= shreg;
                rx_done <= 1'b1;
              end else begin
                frame_err <= 1'b1;
                armed     <= 1'b0;
              end
            end else begin
              scnt <= scnt + SW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage: data shifter, LSB first; contents only matter once a frame completes
  always_ff @(posedge clk) begin
    if ((state == DATA) && full_pt) shreg[bit_idx] <= rx_s;
  end

endmodule

// File: rtl/uart_event_rx.sv
// Event receiver top: UART core followed by a registered decode stage
// that turns event codes 0x40..0x45 into one-hot strobes and flags any
// other good byte as unknown.
module uart_event_rx
  import uart_event_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int OVS      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  output logic [7:0]         rx_data,
  output logic               rx_done,
  output logic               frame_err,
  output logic [EVT_NUM-1:0] evt_pulse,
  output logic               unknown_code,
  output logic               busy
);

  logic [7:0]         data_p0;
  logic               vld_p0;
  logic               ferr_p0;
  logic [EVT_NUM-1:0] evt_p1;
  logic               unk_p1;
  logic [EVT_NUM:0]   dec_p0;

  // Returns {unknown, one-hot event}; exactly one bit is ever set.
  function automatic logic [EVT_NUM:0] decode_code(input logic [7:0] code);
    logic [7:0]       off;
    logic [EVT_NUM:0] res;
    off = code - EVT_BASE;
    res = '0;
    if ((code >= EVT_BASE) && (off < 8'(EVT_NUM))) res[off[2:0]] = 1'b1;
    else res[EVT_NUM] = 1'b1;
    return res;
  endfunction

  uart_rx_core #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .OVS      (OVS)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (data_p0),
    .rx_done   (vld_p0),
    .frame_err (ferr_p0),
    .busy      (busy)
  );

  assign dec_p0 = decode_code(data_p0);

  // Stage p0 -> p1: decode register, fires only on good frames
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evt_p1 <= '0;
      unk_p1 <= 1'b0;
    end else if (vld_p0) begin
      evt_p1 <= dec_p0[EVT_NUM-1:0];
      unk_p1 <= dec_p0[EVT_NUM];
    end else begin
      evt_p1 <= '0;
      unk_p1 <= 1'b0;
    end
  end

  assign rx_data      = data_p0;
  assign rx_done      = vld_p0;
  assign frame_err    = ferr_p0;
  assign evt_pulse    = evt_p1;
  assign unknown_code = unk_p1;

endmodule

// File: tb/tb_uart_event_rx.sv
// Scoreboard bench for uart_event_rx: the stimulus process pushes the
// expected frame outcome and decode result for each byte it sends; an
// independent monitor pops and compares whenever the DUT reports.
module tb_uart_event_rx;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int OVS      = 16;
  localparam int BIT_CLKS = 160;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic [5:0] evt_pulse;
  logic       unknown_code;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit         ferr;
    logic [7:0] data;
  } frame_exp_t;

  frame_exp_t frame_q[$];
  logic [6:0] dec_q[$];
  logic [7:0] last_good = 8'h00;
  bit         prev_done = 1'b0;
  frame_exp_t fexp;
  logic [6:0] dexp;

  uart_event_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .OVS      (OVS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .frame_err    (frame_err),
    .evt_pulse    (evt_pulse),
    .unknown_code (unknown_code),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference decode: {unknown, one-hot event}
  function automatic logic [6:0] ref_decode(input logic [7:0] b);
    int k;
    k = int'(b) - 64;
    if (k >= 0 && k <= 5) return {1'b0, 6'(1 << k)};
    return 7'b100_0000;
  endfunction

  task automatic drive(input int n, input logic v);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    frame_exp_t f;
    f.ferr = !stop_ok;
    f.data = b;
    frame_q.push_back(f);
    if (stop_ok) dec_q.push_back(ref_decode(b));
    drive(BIT_CLKS, 1'b0);
    for (int i = 0; i < 8; i++) drive(BIT_CLKS, b[i]);
    drive(BIT_CLKS, stop_ok);
    if (!stop_ok) drive(2 * BIT_CLKS, 1'b1);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((frame_q.size() != 0 || dec_q.size() != 0) && k < 4000) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    check("drain_pending", frame_q.size() + dec_q.size(), 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a result
  always @(negedge clk) begin
    if (!reset) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) begin
        if (dec_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL decode_underflow: got %0h, expected nothing queued", {unknown_code, evt_pulse});
        end else begin
          dexp = dec_q.pop_front();
          check("decode", {unknown_code, evt_pulse}, dexp);
        end
      end else if (evt_pulse != 6'b0 || unknown_code) begin
        n_cmp++; n_bad++;
        $display("FAIL spurious_decode: got %0h, expected 0 (t=%0t)", {unknown_code, evt_pulse}, $time);
      end
      if (rx_done || frame_err) begin
        if (frame_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_frame: got done=%0b ferr=%0b, expected none", rx_done, frame_err);
        end else begin
          fexp = frame_q.pop_front();
          check("frame_kind", {rx_done, frame_err}, fexp.ferr ? 2'b01 : 2'b10);
          check("rx_data", rx_data, fexp.ferr ? last_good : fexp.data);
          if (!fexp.ferr) last_good = fexp.data;
        end
      end
      prev_done = rx_done;
    end
  end

  initial begin
    logic [7:0] b;
    bit         ok;
    int         gap;

    // Reset, then an idle line must leave everything quiet
    repeat (10) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      check("idle_quiet", {rx_data, rx_done, frame_err, evt_pulse, unknown_code, busy}, 0);
    end

    // Single event byte
    send_frame(8'h42, 1'b1);
    wait_drain();

    // All six events back-to-back, no idle gap
    for (int k = 0; k < 6; k++) send_frame(8'h40 + 8'(k), 1'b1);
    wait_drain();

    // Good byte outside the event range
    send_frame(8'h7A, 1'b1);
    wait_drain();

    // Stop bit low: frame error, data retained
    send_frame(8'h41, 1'b0);
    wait_drain();

    // Start glitch shorter than half a bit
    rx = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_busy_high", busy, 1);
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_busy_low", busy, 0);

    // Reset asserted mid-frame during bit 3
    b = 8'h43;
    drive(BIT_CLKS, 1'b0);
    for (int i = 0; i < 3; i++) drive(BIT_CLKS, b[i]);
    rx = b[3];
    repeat (80) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("mid_reset_outputs", {rx_data, rx_done, frame_err, evt_pulse, unknown_code, busy}, 0);
    last_good = 8'h00;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_idle", {rx_data, busy}, 0);
    send_frame(8'h43, 1'b1);
    wait_drain();

    // Randomized traffic with random gaps and occasional bad stop bits
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 1) == 1) b = 8'h40 + 8'($urandom_range(0, 5));
      else b = 8'($urandom);
      ok  = ($urandom_range(0, 6) != 0);
      gap = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 400));
      send_frame(b, ok);
      if (gap > 0) drive(gap, 1'b1);
    end
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
